// File: rtl/i2s_tx_ctrl_pkg.sv
// Shared types and defaults for the I2S transmit sample scheduler.
package i2s_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Single-clock sample FIFO with flush; full flag is registered from the next level.
module i2s_sample_fifo #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PTR_W-1:0]      level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      level_q, level_d;
  logic                  full_q, full_d;
  logic                  do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + PTR_W'(do_push) - PTR_W'(do_pop);
    end
    // A pop at full lowers full_q only after the edge, so a same-cycle push stays refused.
    full_d = (level_d == PTR_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign level_o = level_q;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// Stereo sample scheduler feeding i2s_tx: L/R FIFOs, left-aligned start, mute, underrun fill.
// Optional I2S_TX_CTRL_HOLD_LAST_EN repeats the last popped word per channel on underrun.
module i2s_tx_ctrl
  import i2s_tx_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  mute_i,
  input  logic [WORD_WIDTH-1:0] l_data_i,
  input  logic                  l_valid_i,
  output logic                  l_ready_o,
  input  logic [WORD_WIDTH-1:0] r_data_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic                  i2s_write_i,
  input  logic                  i2s_lr_i,
  output logic [WORD_WIDTH-1:0] i2s_data_o,
  output logic                  running_o,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  running_q, running_d;
  logic                  underrun_q, underrun_d;
  logic                  accept_q, accept_d;
  logic                  underrun_set, flush;

  logic                  l_push, l_pop, l_full, l_empty;
  logic                  r_push, r_pop, r_full, r_empty;
  logic [WORD_WIDTH-1:0] l_head, r_head, l_fill, r_fill;
  logic [PTR_W-1:0]      l_level, r_level;

  assign l_ready_o = accept_q && !l_full;
  assign r_ready_o = accept_q && !r_full;
  assign l_push    = l_valid_i && l_ready_o;
  assign r_push    = r_valid_i && r_ready_o;

  i2s_sample_fifo #(.WORD_WIDTH(WORD_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_l_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush), .push_i(l_push), .data_i(l_data_i),
    .pop_i(l_pop), .data_o(l_head), .full_o(l_full), .empty_o(l_empty), .level_o(l_level)
  );

  i2s_sample_fifo #(.WORD_WIDTH(WORD_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_r_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush), .push_i(r_push), .data_i(r_data_i),
    .pop_i(r_pop), .data_o(r_head), .full_o(r_full), .empty_o(r_empty), .level_o(r_level)
  );

`ifdef I2S_TX_CTRL_HOLD_LAST_EN
  logic [WORD_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;

  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (!enable_i) begin
      hold_l_d = '0;
      hold_r_d = '0;
    end else begin
      if (l_pop) hold_l_d = l_head;
      if (r_pop) hold_r_d = r_head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

  assign l_fill = hold_l_q;
  assign r_fill = hold_r_q;
`else
  assign l_fill = '0;
  assign r_fill = '0;
`endif

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    underrun_set = 1'b0;
    l_pop        = 1'b0;
    r_pop        = 1'b0;
    flush        = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          flush   = 1'b1;
          data_d  = '0;
        end
        ST_PRIME: begin
          // Start only on a left slot with a full pair available, fixing L/R pairing.
          if (i2s_write_i) begin
            data_d = '0;
            if (!i2s_lr_i && (l_level != '0) && (r_level != '0)) begin
              state_d = ST_RUN;
              l_pop   = 1'b1;
              data_d  = mute_i ? '0 : l_head;
            end
          end
        end
        ST_RUN: begin
          if (i2s_write_i) begin
            if (i2s_lr_i) begin
              if (r_empty) begin
                underrun_set = 1'b1;
                data_d       = mute_i ? '0 : r_fill;
              end else begin
                r_pop  = 1'b1;
                data_d = mute_i ? '0 : r_head;
              end
            end else begin
              if (l_empty) begin
                underrun_set = 1'b1;
                data_d       = mute_i ? '0 : l_fill;
              end else begin
                l_pop  = 1'b1;
                data_d = mute_i ? '0 : l_head;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d  = (state_d == ST_RUN);
    accept_d   = (state_d != ST_IDLE);
    underrun_d = underrun_set || (underrun_q && !underrun_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      running_q  <= 1'b0;
      underrun_q <= 1'b0;
      accept_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      running_q  <= running_d;
      underrun_q <= underrun_d;
      accept_q   <= accept_d;
    end
  end

  assign i2s_data_o = data_q;
  assign running_o  = running_q;
  assign underrun_o = underrun_q;

endmodule

// File: doc/i2s_tx_ctrl.md
# i2s_tx_ctrl

Stereo sample scheduler between the PS/DMA sample streams and the `i2s_tx` serializer. It buffers left and right 16-bit samples in independent FIFOs and answers each `i2s_tx` word request (`write_o` / `lr_chnl_o`) with the matching channel's next sample. It also handles start-up alignment to a left-channel slot, mute, and underrun fill.

## Interface
- `WORD_WIDTH`, 16, sample width; must equal the `i2s_tx` `WORD_WIDTH`.
- `FIFO_DEPTH`, 8, entries per channel FIFO; power of two, ≥2.
- `clk_i  in  1`  system clock, same clock as `i2s_tx`.
- `rst_i  in  1`  reset, synchronous, active-high.
- `enable_i  in  1`  run request; low = IDLE, FIFOs flushed.
- `mute_i  in  1`  force zero samples while still consuming FIFOs.
- `l_data_i  in  WORD_WIDTH`  left sample in.
- `l_valid_i  in  1`  left sample valid.
- `l_ready_o  out  1`  left FIFO not full.
- `r_data_i  in  WORD_WIDTH`  right sample in.
- `r_valid_i  in  1`  right sample valid.
- `r_ready_o  out  1`  right FIFO not full.
- `i2s_write_i  in  1`  word request, connects to `i2s_tx.write_o`.
- `i2s_lr_i  in  1`  requested channel (0 = left, 1 = right), connects to `i2s_tx.lr_chnl_o`.
- `i2s_data_o  out  WORD_WIDTH`  sample to `i2s_tx.data_i`.
- `running_o  out  1`  high in RUN.
- `underrun_o  out  1`  sticky; set on any request served from an empty FIFO in RUN.
- `underrun_clr_i  in  1`  clears `underrun_o`; set wins if both occur in the same cycle.

## Operation
- **Push:** a sample is written when `x_valid_i && x_ready_o`. `x_ready_o` is registered as `!full`. At full, a push is refused even if a pop occurs in the same cycle; the pop takes effect and ready rises the next cycle.
- **States:**
  - IDLE: FIFOs held empty, pushes refused, `x_ready_o` = 0. Every request is answered with 0.
  - PRIME: entered when `enable_i` = 1. FIFOs accept pushes. Requests are answered with 0 and nothing is popped.
  - RUN: entered on the first request with `i2s_lr_i` = 0 while both FIFOs are non-empty. That request is served from the left FIFO, which fixes L/R pairing.
- **RUN service:** each request pops the FIFO selected by `i2s_lr_i` and drives the popped word, or 0 if `mute_i` = 1.
- **Empty FIFO on request in RUN:** drive 0, do not pop, set `underrun_o`, stay in RUN. The other channel is unaffected.
- **Disable:** `enable_i` = 0 in any state sends the block to IDLE on the next edge. Both FIFOs are flushed and `i2s_data_o` is cleared to 0. A request in that same cycle is answered with 0.
- **Simultaneous push and pop:** on a non-full, non-empty FIFO both happen; the level is unchanged.

## Timing
- **Reset values:** `i2s_data_o` = 0, `l_ready_o` = `r_ready_o` = 0, `running_o` = 0, `underrun_o` = 0, state IDLE, FIFOs empty.
- **Request latency:** the request is seen at edge N; `i2s_data_o` holds the new word from N+1 and stays stable until the next request. `i2s_tx` must sample `data_i` no earlier than N+2.
- **Push-to-pop latency:** minimum 1 cycle; a word pushed at edge N is poppable from edge N+1.
- **Back-to-back requests:** one per cycle is sustainable. The I2S request rate is 1 per 16 SCLK, far below that.
- **Status outputs:** `running_o` and `underrun_o` are registered and change one edge after the causing event.

## Configuration
- `I2S_TX_CTRL_HOLD_LAST_EN`:
  - Defined: an underrun repeats the last word popped from that channel, with per-channel hold registers. Each hold register resets to 0 and is cleared on entry to IDLE.
  - Undefined: an underrun drives 0 and no hold registers are built.
  - `underrun_o` behaves identically in both builds.

## Structure
- **Package `i2s_tx_ctrl_pkg`:** state enum (IDLE, PRIME, RUN), `WORD_WIDTH_DEF` = 16, `FIFO_DEPTH_DEF` = 8.
- **Sub-module `i2s_sample_fifo`:** synchronous FIFO with ports for data, push, pop, flush, full, empty and level, plus a pointer width of `$clog2(FIFO_DEPTH)+1`. It is instantiated twice.
- **Top level:** state machine, output register, sticky flag and optional hold registers.

## Test plan
- **Reset:** hold `rst_i` for 4 cycles with `enable_i` = 1 → all outputs 0 during reset; ready rises 1 cycle after release (PRIME).
- **Alignment:** push L = 0x1111, 0x3333 and R = 0x2222, 0x4444, then issue requests lr = 1, 0, 1, 0, 1 → outputs 0, 0x1111, 0x2222, 0x3333, 0x4444. `running_o` rises after the first lr = 0 request.
- **Full:** push 9 left words into depth 8 → 9th refused with `l_ready_o` = 0; after one left request, `l_ready_o` = 1 on the next cycle and the 9th is accepted.
- **Underrun:** in RUN with the right FIFO empty, issue an lr = 1 request → `i2s_data_o` = 0 (0x4444 if `I2S_TX_CTRL_HOLD_LAST_EN` and the last right word was 0x4444). `underrun_o` = 1 and stays 1 until `underrun_clr_i`.
- **Mute:** in RUN with 0xABCD queued left, assert `mute_i` and issue an lr = 0 request → output 0 and left level decrements by 1.
- **Disable mid-run:** drop `enable_i` with 3 words queued → IDLE next edge, FIFOs empty, `i2s_data_o` = 0; re-enabling requires a new left-aligned start.
